// File: rtl/counter_uart_reporter_pkg.sv
// Shared definitions for the counter status reporter: FSM encoding,
// ASCII frame constants and the frame byte selector.
package counter_uart_reporter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_U    = 8'h55;
  localparam logic [7:0] ASCII_D    = 8'h44;
  localparam logic [7:0] ASCII_R    = 8'h52;
  localparam logic [7:0] ASCII_S    = 8'h53;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int         FRAME_LEN = 9;
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

  // Byte idx of the frame "dddd M E\r\n"; digits thousands first, leading zeros kept.
  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [15:0] bcd,
                                            input logic        mode,
                                            input logic        enable);
    logic [7:0] b;
    b = ASCII_LF;
    case (idx)
      4'd0:    b = ASCII_ZERO + {4'h0, bcd[15:12]};
      4'd1:    b = ASCII_ZERO + {4'h0, bcd[11:8]};
      4'd2:    b = ASCII_ZERO + {4'h0, bcd[7:4]};
      4'd3:    b = ASCII_ZERO + {4'h0, bcd[3:0]};
      4'd4:    b = ASCII_SP;
      4'd5:    b = mode ? ASCII_D : ASCII_U;
      4'd6:    b = enable ? ASCII_R : ASCII_S;
      4'd7:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/counter_uart_reporter_if.sv
// Byte-launch handshake between the reporter and the UART transmitter.
// Handshake: the master pulses tx_start for one cycle with tx_data valid in
// that cycle; the UART raises tx_busy the following cycle and holds it while
// shifting; the master launches the next byte only after tx_busy falls.
interface counter_uart_reporter_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/counter_uart_reporter_bin2bcd_seq.sv
// Sequential double-dabble (bin2bcd_seq): CNT_W-bit binary to four BCD digits.
// i_start loads the operand; CNT_W shift steps follow, one per cycle.
// o_done is high in the cycle whose clock edge performs the final step, so
// o_bcd holds the finished result from the next cycle until the next i_start.
module counter_uart_reporter_bin2bcd_seq #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_bin,
  output logic             o_done,
  output logic [15:0]      o_bcd
);

  localparam int CW = $clog2(CNT_W + 1);

  logic [15:0]      r_bcd;
  logic [CNT_W-1:0] r_bin;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [15:0]      w_adj;

  // Add 3 to every digit that is 5 or more before the next shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one binary bit into the BCD digits per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd  <= '0;
      r_bin  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bcd  <= '0;
      r_bin  <= i_bin;
      r_cnt  <= CW'(CNT_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= 16'({w_adj, r_bin[CNT_W-1]});
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/counter_uart_reporter.sv
// UART status reporter: snapshots count/mode/enable on request (pulse or
// periodic tick), converts the count to decimal and sends a 9-byte ASCII
// frame "dddd M E\r\n" through the UART tx_start/tx_busy handshake.
module counter_uart_reporter
  import counter_uart_reporter_pkg::*;
#(
  parameter int          CNT_W         = 14,
  parameter int          MAX_VAL       = 9999,
  parameter int unsigned REPORT_PERIOD = 100_000_000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CNT_W-1:0]                count_reg,
  input  logic                            mode,
  input  logic                            enable,
  input  logic                            report_req,
  counter_uart_reporter_if.master         tx,
  output logic                            report_busy,
  output state_t                          dbg_state
);

  localparam logic [CNT_W-1:0] MAX_SAT     = CNT_W'(MAX_VAL);
  localparam bit               PERIOD_EN   = (REPORT_PERIOD != 0);
  localparam logic [31:0]      PERIOD_LAST = PERIOD_EN ? 32'(REPORT_PERIOD - 1) : 32'd0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_idx;
  logic             r_pending;
  logic             r_snap_mode;
  logic             r_snap_en;
  logic [31:0]      r_period_cnt;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;

  logic             w_tick;
  logic             w_request;
  logic             w_busy_state;
  logic             w_snapshot;
  logic             w_fire;
  logic             w_idx_clr;
  logic             w_idx_adv;
  logic             w_bcd_done;
  logic [15:0]      w_bcd;
  logic [CNT_W-1:0] w_sat;

  assign w_tick       = PERIOD_EN && (r_period_cnt == PERIOD_LAST);
  assign w_request    = report_req | w_tick;
  assign w_sat        = (count_reg > MAX_SAT) ? MAX_SAT : count_reg;
  assign w_busy_state = (r_state != ST_IDLE) && (r_state != ST_DONE);

  // Free-running period counter; wraps on the tick, idle when disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_period_cnt <= '0;
    end else if (PERIOD_EN) begin
      r_period_cnt <= w_tick ? 32'd0 : r_period_cnt + 32'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state plus the single-cycle strobes that steer the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_snapshot  = 1'b0;
    w_fire      = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_adv   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_request) begin
          w_snapshot  = 1'b1;
          w_state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (w_bcd_done) begin
          w_idx_clr   = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx.tx_busy) begin
          w_fire      = 1'b1;
          w_state_nxt = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx.tx_busy) w_state_nxt = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!tx.tx_busy) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_adv   = 1'b1;
            w_state_nxt = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        // A request arriving in this very cycle is treated as pending.
        if (r_pending || w_request) begin
          w_snapshot  = 1'b1;
          w_state_nxt = ST_CONVERT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One-deep pending flag: set by a request during a frame, consumed in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_pending <= 1'b0;
    end else if (w_request && w_busy_state) begin
      r_pending <= 1'b1;
    end
  end

  // Snapshot of mode/enable, byte index and the registered tx outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap_mode <= 1'b0;
      r_snap_en   <= 1'b0;
      r_idx       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      if (w_snapshot) begin
        r_snap_mode <= mode;
        r_snap_en   <= enable;
      end
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_adv) r_idx <= r_idx + 4'd1;
      r_tx_start <= w_fire;
      if (w_fire) r_tx_data <= frame_byte(r_idx, w_bcd, r_snap_mode, r_snap_en);
    end
  end

  counter_uart_reporter_bin2bcd_seq #(.CNT_W(CNT_W)) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_snapshot),
    .i_bin   (w_sat),
    .o_done  (w_bcd_done),
    .o_bcd   (w_bcd)
  );

  assign tx.tx_start = r_tx_start;
  assign tx.tx_data  = r_tx_data;
  assign report_busy = w_busy_state;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_counter_uart_reporter.sv
// Bench for counter_uart_reporter: two instances (periodic reports off and
// REPORT_PERIOD=200), each with a UART busy model, byte capture monitors and
// a frame reference model built from plain decimal arithmetic.
module tb_counter_uart_reporter;
  import counter_uart_reporter_pkg::*;

  localparam int BUSY_A = 20;
  localparam int BUSY_P = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [13:0] count_a = '0;
  logic        mode_a  = 1'b0;
  logic        en_a    = 1'b0;
  logic        req_a   = 1'b0;
  logic        rbusy_a;
  state_t      st_a;

  logic [13:0] count_p = 14'd5678;
  logic        mode_p  = 1'b1;
  logic        en_p    = 1'b1;
  logic        req_p   = 1'b0;
  logic        rbusy_p;
  state_t      st_p;

  counter_uart_reporter_if if_a ();
  counter_uart_reporter_if if_p ();

  counter_uart_reporter #(.CNT_W(14), .MAX_VAL(9999), .REPORT_PERIOD(0)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .count_reg   (count_a),
    .mode        (mode_a),
    .enable      (en_a),
    .report_req  (req_a),
    .tx          (if_a),
    .report_busy (rbusy_a),
    .dbg_state   (st_a)
  );

  counter_uart_reporter #(.CNT_W(14), .MAX_VAL(9999), .REPORT_PERIOD(200)) dut_p (
    .clk         (clk),
    .rst         (rst),
    .count_reg   (count_p),
    .mode        (mode_p),
    .enable      (en_p),
    .report_req  (req_p),
    .tx          (if_p),
    .report_busy (rbusy_p),
    .dbg_state   (st_p)
  );

  // ---------------- UART busy models ----------------
  int ua_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_a.tx_busy <= 1'b0;
      ua_cnt       <= 0;
    end else if (if_a.tx_start) begin
      if_a.tx_busy <= 1'b1;
      ua_cnt       <= BUSY_A;
    end else if (ua_cnt > 0) begin
      ua_cnt       <= ua_cnt - 1;
      if_a.tx_busy <= (ua_cnt > 1);
    end
  end

  int up_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_p.tx_busy <= 1'b0;
      up_cnt       <= 0;
    end else if (if_p.tx_start) begin
      if_p.tx_busy <= 1'b1;
      up_cnt       <= BUSY_P;
    end else if (up_cnt > 0) begin
      up_cnt       <= up_cnt - 1;
      if_p.tx_busy <= (up_cnt > 1);
    end
  end

  // ---------------- capture monitors ----------------
  logic [7:0] got_a[$];
  int         tsa[$];
  logic [7:0] got_p[$];
  int         tsp[$];

  always @(negedge clk) begin
    if (if_a.tx_start === 1'b1) begin
      got_a.push_back(if_a.tx_data);
      tsa.push_back(cyc);
    end
    if (if_p.tx_start === 1'b1) begin
      got_p.push_back(if_p.tx_data);
      tsp.push_back(cyc);
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int req_cyc = 0;

  function automatic void model_frame(input int c, input bit m, input bit e);
    int v;
    v = (c > 9999) ? 9999 : c;
    exp_q.push_back(8'h30 + 8'(v / 1000));
    exp_q.push_back(8'h30 + 8'((v / 100) % 10));
    exp_q.push_back(8'h30 + 8'((v / 10) % 10));
    exp_q.push_back(8'h30 + 8'(v % 10));
    exp_q.push_back(8'h20);
    exp_q.push_back(m ? 8'h44 : 8'h55);
    exp_q.push_back(e ? 8'h52 : 8'h53);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_a();
    @(posedge clk); #1;
    req_a   = 1'b1;
    req_cyc = cyc;
    @(posedge clk); #1;
    req_a   = 1'b0;
  endtask

  task automatic wait_bytes_a(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (got_a.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    ok = (got_a.size() >= n);
  endtask

  task automatic start_case(input logic [13:0] c, input logic m, input logic e);
    got_a.delete();
    tsa.delete();
    exp_q.delete();
    @(posedge clk); #1;
    count_a = c;
    mode_a  = m;
    en_a    = e;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if_a.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", if_a.tx_start); end
    checks++; if (if_a.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", if_a.tx_data); end
    checks++; if (rbusy_a !== 1'b0) begin errors++; $display("FAIL reset_report_busy got=%b exp=0", rbusy_a); end
    checks++; if (st_a !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", st_a, ST_IDLE); end
    rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_frame(input string name, input logic [13:0] c, input logic m, input logic e);
    bit ok;
    start_case(c, m, e);
    model_frame(int'(c), m, e);
    pulse_a();
    checks++; if (rbusy_a !== 1'b1) begin errors++; $display("FAIL %s_busy_after_snapshot got=%b exp=1", name, rbusy_a); end
    count_a = 14'($urandom_range(0, 16383));
    mode_a  = ~m;
    en_a    = ~e;
    wait_bytes_a(9, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout got=%0d bytes exp=9", name, got_a.size()); end
    checks++; if (ok && (tsa[0] - req_cyc) !== 16) begin errors++; $display("FAIL %s_latency got=%0d exp=16", name, tsa[0] - req_cyc); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (rbusy_a !== 1'b0) begin errors++; $display("FAIL %s_busy_end got=%b exp=0", name, rbusy_a); end
    checks++; if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL %s_len got=%0d exp=%0d", name, got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_byte%0d got=%h exp=%h", name, i, (i < got_a.size()) ? got_a[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [13:0] c;
    logic m, e;
    for (int n = 0; n < 3; n++) begin
      c = 14'($urandom_range(0, 16383));
      m = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      test_frame("random", c, m, e);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    start_case(14'd1111, 1'b0, 1'b1);
    model_frame(1111, 1'b0, 1'b1);
    model_frame(42, 1'b1, 1'b1);
    pulse_a();
    wait_bytes_a(2, 400, ok);
    @(posedge clk); #1;
    count_a = 14'd42;
    mode_a  = 1'b1;
    pulse_a();
    repeat (30) @(posedge clk);
    pulse_a();
    wait_bytes_a(18, 900, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got=%0d bytes exp=18", got_a.size()); end
    repeat (300) @(posedge clk);
    #1;
    checks++; if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d got=%h exp=%h", i, (i < got_a.size()) ? got_a[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_done_request();
    bit ok;
    int k;
    int done_cyc;
    start_case(14'd777, 1'b0, 1'b0);
    model_frame(777, 1'b0, 1'b0);
    model_frame(8888, 1'b0, 1'b0);
    pulse_a();
    k = 0;
    done_cyc = -100;
    @(negedge clk);
    while (st_a !== ST_DONE && k < 600) begin
      @(negedge clk);
      k++;
    end
    checks++; if (st_a !== ST_DONE) begin errors++; $display("FAIL done_req_reach_done got=%0d exp=%0d", st_a, ST_DONE); end
    count_a  = 14'd8888;
    req_a    = 1'b1;
    done_cyc = cyc;
    @(posedge clk); #1;
    req_a = 1'b0;
    wait_bytes_a(18, 600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL done_req_timeout got=%0d bytes exp=18", got_a.size()); end
    checks++; if (ok && (tsa[9] - done_cyc) !== 16) begin errors++; $display("FAIL done_req_latency got=%0d exp=16", tsa[9] - done_cyc); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL done_req_len got=%0d exp=%0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL done_req_byte%0d got=%h exp=%h", i, (i < got_a.size()) ? got_a[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_case(14'd5555, 1'b1, 1'b0);
    pulse_a();
    wait_bytes_a(4, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_timeout got=%0d bytes exp=4", got_a.size()); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (if_a.tx_start !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_start got=%b exp=0", if_a.tx_start); end
    checks++; if (if_a.tx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_tx_data got=%h exp=00", if_a.tx_data); end
    checks++; if (rbusy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_report_busy got=%b exp=0", rbusy_a); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    got_a.delete();
    repeat (300) @(posedge clk);
    #1;
    checks++; if (got_a.size() != 0) begin errors++; $display("FAIL rst_mid_no_resume got=%0d bytes exp=0", got_a.size()); end
    checks++; if (rbusy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_idle_busy got=%b exp=0", rbusy_a); end
  endtask

  task automatic test_no_periodic();
    got_a.delete();
    repeat (600) @(posedge clk);
    #1;
    checks++; if (got_a.size() != 0) begin errors++; $display("FAIL no_periodic got=%0d bytes exp=0", got_a.size()); end
  endtask

  task automatic test_periodic();
    int k;
    k = 0;
    @(negedge clk);
    while (rbusy_p !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    got_p.delete();
    tsp.delete();
    exp_q.delete();
    for (int f = 0; f < 4; f++) model_frame(5678, 1'b1, 1'b1);
    k = 0;
    while (got_p.size() < 36 && k < 1500) begin
      @(posedge clk);
      k++;
    end
    checks++; if (got_p.size() < 36) begin errors++; $display("FAIL periodic_timeout got=%0d bytes exp=36", got_p.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_p.size() || got_p[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL periodic_byte%0d got=%h exp=%h", i, (i < got_p.size()) ? got_p[i] : 8'hxx, exp_q[i]);
      end
    end
    for (int f = 1; f < 4; f++) begin
      checks++;
      if (tsp.size() < 36 || (tsp[9*f] - tsp[9*(f-1)]) != 200) begin
        errors++;
        $display("FAIL periodic_spacing%0d got=%0d exp=200", f, (tsp.size() >= 36) ? (tsp[9*f] - tsp[9*(f-1)]) : -1);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_frame("basic", 14'd1234, 1'b0, 1'b1);
    test_frame("zero", 14'd0, 1'b1, 1'b0);
    test_frame("saturate", 14'd16383, 1'b0, 1'b1);
    test_frame("max_val", 14'd9999, 1'b1, 1'b1);
    test_frame("above_max", 14'd10000, 1'b0, 1'b0);
    test_random();
    test_back_to_back();
    test_done_request();
    test_reset_mid();
    test_no_periodic();
    test_periodic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
